// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time over req/ready,
// WAIT programmable wait states, byte-enabled stores and an out-of-range error.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT        = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITING,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        access;
    logic        acc_sel;
    logic        acc_we;
    logic [3:0]  acc_be;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] acc_pc;
    logic [31:0] word_off;
    logic [31:0] word_addr;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] mem_rd;
    logic [31:0] merged;
    logic        mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    be_d    = be;
                    addr_d  = addr;
                    wdata_d = wdata;
                    pc_d    = pc;
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = S_WAITING;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAITING: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With WAIT=0 the access happens on the accept edge itself, so the
    // live request fields are used instead of the (not yet loaded) latches.
    always_comb begin
        acc_sel   = (state_q == S_IDLE);
        acc_we    = acc_sel ? we    : we_q;
        acc_be    = acc_sel ? be    : be_q;
        acc_addr  = acc_sel ? addr  : addr_q;
        acc_wdata = acc_sel ? wdata : wdata_q;
        acc_pc    = acc_sel ? pc    : pc_q;
        word_off  = acc_addr - BASE_ADDR;
        word_addr = {2'b00, word_off[31:2]};
        in_range  = (word_addr < 32'(DEPTH_WORDS));
        idx       = word_addr[AW-1:0];
        mem_rd    = in_range ? mem_q[idx] : '0;
        merged    = mem_rd;
        for (int unsigned b = 0; b < 4; b++) begin
            if (acc_be[b]) merged[8*b +: 8] = acc_wdata[8*b +: 8];
        end
    end

    always_comb begin
        mem_we  = access && acc_we && in_range;
        rdata_d = (access && !acc_we && in_range) ? mem_rd : '0;
        err_d   = access && !in_range;
        ready_d = access;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            $display("@%h: *%h <= %h", acc_pc, {word_addr[29:0], 2'b00}, merged);
        end
    end
`endif

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: WAIT=2 instance for timing/data/range/reset,
// WAIT=0 instance for back-to-back acceptance.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req2;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, pc;
    logic [31:0] rdata0, rdata2;
    logic        ready0, ready2, err0, err2, busy0, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(1024), .WAIT(2), .BASE_ADDR(32'h0)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .pc(pc), .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2)
    );

    dm_responder #(.DEPTH_WORDS(1024), .WAIT(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .pc(pc), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for ready; returns to IDLE afterwards.
    task automatic txn(input bit use0, input logic we_v, input logic [3:0] be_v,
                       input logic [31:0] addr_v, input logic [31:0] wdata_v,
                       output logic [31:0] rd, output logic e, output int lat);
        bit got = 0;
        we = we_v; be = be_v; addr = addr_v; wdata = wdata_v; pc = 32'h0000_0400;
        if (use0) req0 = 1'b1; else req2 = 1'b1;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if (use0 ? ready0 : ready2) got = 1;
        end
        rd = use0 ? rdata0 : rdata2;
        e  = use0 ? err0 : err2;
        req0 = 1'b0; req2 = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL txn_timeout: ready not seen within 20 cycles, addr %h", addr_v);
        end
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({ready2, err2, busy2, rdata2} !== 35'd0) begin
            n_fail++; $display("FAIL reset_w2: got %h required 0", {ready2, err2, busy2, rdata2});
        end
        n_checks++;
        if ({ready0, err0, busy0, rdata0} !== 35'd0) begin
            n_fail++; $display("FAIL reset_w0: got %h required 0", {ready0, err0, busy0, rdata0});
        end
    endtask

    task automatic test_store_timing();
        logic [2:0] obs_r [4];
        logic [3:0] obs_b;
        we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'hDEADBEEF; pc = 32'h0000_0100;
        req2 = 1'b1;
        obs_r[0] = {ready2, err2, busy2};
        for (int c = 1; c < 4; c++) begin
            tick();
            obs_r[c] = {ready2, err2, busy2};
            if (ready2) req2 = 1'b0;
        end
        obs_b = {obs_r[3][0], obs_r[2][0], obs_r[1][0], obs_r[0][0]};
        n_checks++;
        if ({obs_r[3][2], obs_r[2][2], obs_r[1][2], obs_r[0][2]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL store_ready_timing: got %b required 1000",
                     {obs_r[3][2], obs_r[2][2], obs_r[1][2], obs_r[0][2]});
        end
        n_checks++;
        if (obs_b !== 4'b1110) begin
            n_fail++; $display("FAIL store_busy_timing: got %b required 1110", obs_b);
        end
        n_checks++;
        if ({err2, rdata2} !== 33'd0) begin
            n_fail++; $display("FAIL store_resp_data: got %h required 0", {err2, rdata2});
        end
        tick();
        n_checks++;
        if ({ready2, busy2} !== 2'b00) begin
            n_fail++; $display("FAIL store_idle_after: got %b required 00", {ready2, busy2});
        end
    endtask

    task automatic test_load();
        logic [31:0] rd; logic e; int lat;
        txn(0, 1'b0, 4'h0, 32'h10, 32'hFFFF_FFFF, rd, e, lat);
        n_checks++;
        if ({e, rd} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL load_data: got %h required 0deadbeef", {e, rd});
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL load_latency: got %0d required 3", lat);
        end
        n_checks++;
        if ({ready2, rdata2} !== 33'd0) begin
            n_fail++; $display("FAIL load_one_cycle: got %h required 0", {ready2, rdata2});
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic e; int lat;
        txn(0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, rd, e, lat);
        txn(0, 1'b0, 4'h0, 32'h11, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin
            n_fail++; $display("FAIL byte_merge: got %h required deadaaef", rd);
        end
        txn(0, 1'b1, 4'b0000, 32'h10, 32'h1234_5678, rd, e, lat);
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin
            n_fail++; $display("FAIL be_zero_noop: got %h required deadaaef", rd);
        end
        txn(0, 1'b1, 4'b1001, 32'hFFC, 32'hA1B2C3D4, rd, e, lat);
        txn(0, 1'b0, 4'h0, 32'hFFC, 32'h0, rd, e, lat);
        n_checks++;
        if ({e, rd} !== {1'b0, 32'hA10000D4}) begin
            n_fail++; $display("FAIL top_word: got %h required 0a10000d4", {e, rd});
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int lat;
        txn(0, 1'b0, 4'h0, 32'h1000, 32'h0, rd, e, lat);
        n_checks++;
        if ({e, rd} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL oor_load: got %h required 100000000", {e, rd});
        end
        txn(0, 1'b1, 4'hF, 32'h1000, 32'h5555_5555, rd, e, lat);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL oor_store_err: got %b required 1", e);
        end
        txn(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, e, lat);
        n_checks++;
        if ({e, rd} !== 33'd0) begin
            n_fail++; $display("FAIL oor_no_alias: got %h required 0", {e, rd});
        end
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'hDEADAAEF) begin
            n_fail++; $display("FAIL oor_array_kept: got %h required deadaaef", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat;
        logic [4:0] rdy, bsy;
        logic [31:0] d2, d4;
        txn(1, 1'b1, 4'hF, 32'h20, 32'h1234_5678, rd, e, lat);
        n_checks++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL w0_latency: got %0d required 1", lat);
        end
        we = 1'b0; be = 4'h0; addr = 32'h20;
        req0 = 1'b1;
        rdy[0] = ready0; bsy[0] = busy0;
        for (int c = 1; c < 4; c++) begin
            tick();
            rdy[c] = ready0; bsy[c] = busy0;
            if (c == 1) d2 = rdata0;
            if (c == 3) d4 = rdata0;
        end
        req0 = 1'b0;
        tick();
        rdy[4] = ready0; bsy[4] = busy0;
        n_checks++;
        if (rdy !== 5'b01010) begin
            n_fail++; $display("FAIL b2b_ready: got %b required 01010 (cycle5..1)", rdy);
        end
        n_checks++;
        if (bsy !== 5'b01010) begin
            n_fail++; $display("FAIL b2b_busy: got %b required 01010 (cycle5..1)", bsy);
        end
        n_checks++;
        if ({d2, d4} !== {32'h1234_5678, 32'h1234_5678}) begin
            n_fail++; $display("FAIL b2b_data: got %h required 1234567812345678", {d2, d4});
        end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] rd; logic e; int lat;
        we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'hCAFEF00D; pc = 32'h200;
        req2 = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy2 !== 1'b1) begin
            n_fail++; $display("FAIL inflight_busy: got %b required 1", busy2);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({ready2, err2, busy2, rdata2} !== 35'd0) begin
            n_fail++; $display("FAIL reset_async: got %h required 0", {ready2, err2, busy2, rdata2});
        end
        req2 = 1'b0;
        #2 reset = 1'b1;
        tick();
        n_checks++;
        if ({ready2, busy2} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: got %b required 00", {ready2, busy2});
        end
        txn(0, 1'b0, 4'h0, 32'h40, 32'h0, rd, e, lat);
        n_checks++;
        if ({e, rd} !== 33'd0) begin
            n_fail++; $display("FAIL reset_dropped_write: got %h required 0", {e, rd});
        end
        txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, lat);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_array_clear: got %h required 0", rd);
        end
    endtask

    initial begin
        reset = 1'b0; req0 = 1'b0; req2 = 1'b0; we = 1'b0; be = '0;
        addr = '0; wdata = '0; pc = '0;
        test_reset();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        test_store_timing();
        test_load();
        test_byte_enables();
        test_out_of_range();
        test_back_to_back();
        test_reset_in_flight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
